// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, oversample ratio and the capture FSM encoding.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    typedef enum logic [0:0] {
        CAP_IDLE = 1'b0,
        CAP_ACK  = 1'b1
    } cap_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; owns storage, pointers, occupancy
// and push/pop arbitration (a push into a full FIFO is taken only alongside a pop).
module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic [AW:0]      count,
    output logic             push_acc
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full;
    logic             pop;

    always_comb begin
        full     = (count_q == FULL_CNT);
        pop      = pop_req && (count_q != '0);
        push_acc = push && (!full || pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_acc, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the cleared pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= push_data;
    end

    assign m_data  = mem_q[rd_ptr_q];
    assign m_valid = (count_q != '0);
    assign count   = count_q;

endmodule

// File: rtl/rx_buffer.sv
// Receive byte buffer: captures each byte from the UART receiver with a one-cycle
// ready_clr acknowledge, queues it in a FWFT FIFO and flags bytes dropped on full.
module rx_buffer
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rx_ready,
    output logic                   ready_clr,
    output logic [UART_DATA_W-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [AW:0]            count,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    cap_state_e state_q, state_d;
    logic       overflow_q, overflow_d;
    logic       push_req;
    logic       push_acc;
    logic       drop;

    // rx_ready stays high through the ACK cycle, so ACK must not look at it again.
    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        case (state_q)
            CAP_IDLE: begin
                if (rx_ready) begin
                    push_req = 1'b1;
                    state_d  = CAP_ACK;
                end
            end
            CAP_ACK:  state_d = CAP_IDLE;
            default:  state_d = CAP_IDLE;
        endcase
    end

    // Set beats clear so a drop coinciding with ovf_clr is never lost.
    always_comb begin
        drop = push_req && !push_acc;
        if (drop)         overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;
        else              overflow_d = overflow_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CAP_IDLE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    assign ready_clr = (state_q == CAP_ACK);
    assign overflow  = overflow_q;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (rx_data),
        .pop_req   (m_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .count     (count),
        .push_acc  (push_acc)
    );

endmodule

// File: tb/tb_rx_buffer.sv
// Directed self-checking bench for rx_buffer (DEPTH=16).
module tb_rx_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       ready_clr;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rx_buffer #(.DEPTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .ready_clr (ready_clr),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; m_ready = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Receiver model: raise ready, drop it once the ack cycle has been seen.
    task automatic send_byte(input logic [7:0] d, input logic pop_too, output int pulses);
        @(negedge clk);
        rx_data = d; rx_ready = 1'b1; m_ready = pop_too;
        @(negedge clk);
        pulses = int'(ready_clr);
        rx_ready = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        pulses += int'(ready_clr);
    endtask

    task automatic pop_byte(output logic [7:0] d, output logic v);
        @(negedge clk);
        d = m_data; v = m_valid; m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (ready_clr !== 1'b0) begin n_errors++; $display("FAIL reset_ready_clr: got %b want 0", ready_clr); end
        n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_single();
        logic [7:0] d; logic v;
        do_reset();
        @(negedge clk);
        rx_data = 8'hA5; rx_ready = 1'b1;
        n_checks++; if (ready_clr !== 1'b0) begin n_errors++; $display("FAIL single_clr_early: got %b want 0", ready_clr); end
        @(negedge clk);
        n_checks++; if (ready_clr !== 1'b1) begin n_errors++; $display("FAIL single_clr_pulse: got %b want 1", ready_clr); end
        n_checks++; if (m_valid !== 1'b1) begin n_errors++; $display("FAIL single_m_valid: got %b want 1", m_valid); end
        n_checks++; if (m_data !== 8'hA5) begin n_errors++; $display("FAIL single_m_data: got %h want a5", m_data); end
        n_checks++; if (count !== 5'd1) begin n_errors++; $display("FAIL single_count: got %0d want 1", count); end
        rx_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (ready_clr !== 1'b0) begin n_errors++; $display("FAIL single_clr_end: got %b want 0", ready_clr); end
        n_checks++; if (count !== 5'd1) begin n_errors++; $display("FAIL single_one_push: got %0d want 1", count); end
        pop_byte(d, v);
        n_checks++; if (d !== 8'hA5 || v !== 1'b1) begin n_errors++; $display("FAIL single_pop: got %h/%b want a5/1", d, v); end
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL single_count_after_pop: got %0d want 0", count); end
        n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL single_valid_after_pop: got %b want 0", m_valid); end
    endtask

    task automatic test_order_wrap();
        int p; int tot; int exp; int max_cnt; logic [7:0] d; logic v;
        do_reset();
        tot = 0; exp = 0; max_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            send_byte(8'(i), 1'b0, p); tot += p;
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        for (int i = 0; i < 4; i++) begin
            pop_byte(d, v);
            n_checks++; if (d !== 8'(exp) || v !== 1'b1) begin n_errors++; $display("FAIL order_pop%0d: got %h/%b want %h/1", exp, d, v, 8'(exp)); end
            exp++;
        end
        for (int i = 12; i < 20; i++) begin
            send_byte(8'(i), 1'b0, p); tot += p;
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL order_count_full: got %0d want 16", count); end
        for (int i = 0; i < 16; i++) begin
            pop_byte(d, v);
            n_checks++; if (d !== 8'(exp) || v !== 1'b1) begin n_errors++; $display("FAIL order_pop%0d: got %h/%b want %h/1", exp, d, v, 8'(exp)); end
            exp++;
        end
        n_checks++; if (tot !== 20) begin n_errors++; $display("FAIL order_ack_pulses: got %0d want 20", tot); end
        n_checks++; if (max_cnt > 16) begin n_errors++; $display("FAIL order_max_count: got %0d want <=16", max_cnt); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL order_overflow: got %b want 0", overflow); end
        n_checks++; if (count !== 5'd0 || m_valid !== 1'b0) begin n_errors++; $display("FAIL order_drained: got %0d/%b want 0/0", count, m_valid); end
    endtask

    task automatic test_overflow();
        int p; logic [7:0] d; logic v;
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b0, p);
        n_checks++; if (count !== 5'd16 || overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_fill: got %0d/%b want 16/0", count, overflow); end
        send_byte(8'h77, 1'b0, p);
        n_checks++; if (p !== 1) begin n_errors++; $display("FAIL ovf_ack: got %0d pulses want 1", p); end
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL ovf_count: got %0d want 16", count); end
        n_checks++; if (m_data !== 8'h10) begin n_errors++; $display("FAIL ovf_head: got %h want 10", m_data); end
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        for (int i = 0; i < 16; i++) begin
            pop_byte(d, v);
            n_checks++; if (d !== 8'h10 + 8'(i) || v !== 1'b1) begin n_errors++; $display("FAIL ovf_drain%0d: got %h/%b want %h/1", i, d, v, 8'h10 + 8'(i)); end
        end
        n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_no_0x77: got valid %b data %h want valid 0", m_valid, m_data); end
    endtask

    task automatic test_full_pop();
        int p; logic [7:0] d; logic v;
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b0, p);
        send_byte(8'h5C, 1'b1, p);
        n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL fullpop_count: got %0d want 16", count); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL fullpop_overflow: got %b want 0", overflow); end
        for (int i = 1; i < 16; i++) begin
            pop_byte(d, v);
            n_checks++; if (d !== 8'h20 + 8'(i) || v !== 1'b1) begin n_errors++; $display("FAIL fullpop_drain%0d: got %h/%b want %h/1", i, d, v, 8'h20 + 8'(i)); end
        end
        pop_byte(d, v);
        n_checks++; if (d !== 8'h5C || v !== 1'b1) begin n_errors++; $display("FAIL fullpop_last: got %h/%b want 5c/1", d, v); end
        n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL fullpop_empty: got %b want 0", m_valid); end
    endtask

    task automatic test_ovf_collision();
        int p;
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), 1'b0, p);
        @(negedge clk);
        rx_data = 8'h99; rx_ready = 1'b1; ovf_clr = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0; ovf_clr = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL collide_set_wins: got %b want 1", overflow); end
        n_checks++; if (m_data !== 8'h40) begin n_errors++; $display("FAIL collide_head: got %h want 40", m_data); end
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL collide_clear: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        int p;
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i), 1'b0, p);
        @(negedge clk);
        rx_data = 8'h3C; rx_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (ready_clr !== 1'b1 || count !== 5'd5) begin n_errors++; $display("FAIL rstmid_in_ack: got clr %b cnt %0d want 1/5", ready_clr, count); end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL rstmid_count: got %0d want 0", count); end
        n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid: got %b want 0", m_valid); end
        n_checks++; if (ready_clr !== 1'b0) begin n_errors++; $display("FAIL rstmid_clr: got %b want 0", ready_clr); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (ready_clr !== 1'b1) begin n_errors++; $display("FAIL rstmid_recap_clr: got %b want 1", ready_clr); end
        n_checks++; if (count !== 5'd1 || m_data !== 8'h3C) begin n_errors++; $display("FAIL rstmid_recap_data: got %0d/%h want 1/3c", count, m_data); end
        rx_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (ready_clr !== 1'b0 || count !== 5'd1) begin n_errors++; $display("FAIL rstmid_single: got %b/%0d want 0/1", ready_clr, count); end
    endtask

    initial begin
        rst_n = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
        test_reset();
        test_single();
        test_order_wrap();
        test_overflow();
        test_full_pop();
        test_ovf_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rx_buffer.md
# rx_buffer

Receive-side byte buffer downstream of the UART receiver. It takes each completed byte from the receiver's `data_out`/`ready` pair and acknowledges it with a one-cycle `ready_clr` pulse. Bytes are stored in a synchronous first-word-fall-through FIFO and presented to the host over a valid/ready stream, with occupancy and a sticky overflow flag.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `AW`, $clog2(DEPTH): pointer width; derived, not overridden.

- `clk`  in  1  system clock, same domain as the receiver.
- `rst_n`  in  1  reset; synchronous, active-low.
- `rx_data`  in  8  receiver `data_out`.
- `rx_ready`  in  1  receiver `ready`; a level, held until cleared.
- `ready_clr`  out  1  acknowledge to receiver `ready_clr`; one-cycle pulse.
- `m_data`  out  8  head-of-FIFO byte; valid while `m_valid`=1.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  host accepts `m_data` this cycle.
- `count`  out  AW+1  entries held, 0..DEPTH.
- `overflow`  out  1  sticky; a byte was dropped because the FIFO was full.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Capture FSM has two states.
  - CAP_IDLE: if `rx_ready`=1, issue a push and go to CAP_ACK.
  - CAP_ACK: `ready_clr`=1 for exactly this cycle; `rx_ready` is ignored; return to CAP_IDLE.
- `ready_clr` is a registered output: high only in CAP_ACK.
- The receiver drops `ready` at the end of the CAP_ACK cycle. One byte therefore produces exactly one push.
- Push is accepted if `count`<DEPTH, or if `count`=DEPTH and a pop occurs in the same cycle.
- Otherwise the byte is discarded and `overflow` is set. The handshake still completes (CAP_ACK, `ready_clr`), so the receiver is never stalled.
- Pop occurs when `m_valid`=1 and `m_ready`=1. `m_ready` while empty has no effect.
- `count` update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Pointers are AW bits and wrap modulo DEPTH.
- `m_data` always shows `mem[rd_ptr]` (first-word fall-through).
- `overflow` update:
  - Set on a dropped push.
  - Cleared by `ovf_clr`.
  - If both occur in the same cycle, set wins.

## Timing
- Reset (`rst_n`=0 at a clk edge):
  - FSM goes to CAP_IDLE.
  - `ready_clr`=0, `m_valid`=0, `count`=0, `overflow`=0.
  - Pointers go to 0; `m_data` is don't-care.
  - FIFO contents are discarded.
- Reset mid-operation (including in CAP_ACK) cancels any pending `ready_clr`. If `rx_ready` is still high after reset, that byte is captured again normally.
- Latency, with `rx_ready` rising before edge N:
  - Push at edge N.
  - `m_valid`=1 and `count` updated after edge N.
  - `ready_clr`=1 in cycle N+1.
- Pop at edge M: the next byte, or `m_valid`=0, is visible after edge M.
- Back-to-back bytes are separated by at least 160 `baud_en` ticks, so the FSM needs no lookahead.
- Simultaneous push and pop on an empty FIFO:
  - The pop is not possible, since `m_valid`=0.
  - The push proceeds.
  - `m_valid` rises the next cycle; there is no bypass.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_DATA_W` = 8.
  - Capture state enum (`CAP_IDLE`, `CAP_ACK`).
  - 16x oversample constant used with the receiver.
- Sub-module `sync_fifo` (parameters DEPTH and width) holds storage, pointers, `count`, and push/pop arbitration.
- `rx_buffer` holds the capture FSM, drop detection and the overflow flag.

## Test plan
- Reset, then one byte: `rx_ready` high with 0xA5.
  - `ready_clr` pulses once, one cycle later.
  - `m_valid`=1, `m_data`=0xA5, `count`=1.
  - Pop with `m_ready`=1, after which `count`=0 and `m_valid`=0.
- Order and wrap-around: push 20 bytes 0x00..0x13 with DEPTH=16, interleaving pops.
  - Host reads 0x00..0x13 in order.
  - `count` never exceeds 16.
  - `overflow` stays 0.
- Overflow: fill 16 bytes with no pops, then deliver 0x77.
  - `ready_clr` still pulses.
  - `overflow`=1 and `count`=16.
  - Head is still byte 0; 0x77 is never output.
  - `ovf_clr` then clears the flag.
- Full with simultaneous pop: `count`=16 with `m_ready`=1 while 0x5C arrives.
  - Push accepted and `count` stays 16.
  - 0x5C emerges last.
  - `overflow`=0.
- Overflow set/clear collision: a drop in the same cycle as `ovf_clr`=1 leaves `overflow`=1.
- Reset mid-operation: assert `rst_n`=0 during CAP_ACK with `count`=5.
  - `count`=0, `m_valid`=0, `ready_clr`=0 next cycle.
  - The still-high `rx_ready` byte is recaptured after reset releases.
